// File: rtl/rr_reg_write_arbiter_if.sv
// Bundle of the request/grant handshake and the shared register view
// exchanged between client blocks and rr_reg_write_arbiter.
// master: the client side (drives requests and data).
// slave : the arbiter side (drives grant, write strobe, register, counter).
interface rr_reg_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WIDTH-1:0]      q;
    logic [CNT_W-1:0]      wcount;

    modport master (
        output req,
        output wdata,
        input  gnt,
        input  wr_en,
        input  q,
        input  wcount
    );

    modport slave (
        input  req,
        input  wdata,
        output gnt,
        output wr_en,
        output q,
        output wcount
    );
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter in front of a single shared enabled register.
// Each cycle at most one eligible requester wins; its data is written into
// the shared register and a one-hot grant is raised for the following cycle
// as the acknowledge. A port granted last cycle is masked out for one cycle
// so registered clients can drop req without causing a double write.
// All outputs come straight from flops; there is no input-to-output path.
module rr_reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_reg_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Registered state
    logic [NREQ-1:0]  gnt_reg;
    logic             wr_en_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CNT_W-1:0] wcount_reg;
    logic [PTR_W-1:0] ptr_reg;

    // Combinational arbitration results
    logic [NREQ-1:0]  elig;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand_idx;
    int               cand;
    logic [NREQ-1:0]  gnt_next;
    logic [PTR_W-1:0] ptr_next;
    logic [WIDTH-1:0] win_data;

    // Per-requester data slices
    logic [WIDTH-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign wdata_arr[gi] = bus.wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The previous grant doubles as the mask: last cycle's winner sits out.
    assign elig = bus.req & ~gnt_reg;

    // Search elig starting at ptr, ascending with wrap-around; first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found) begin
                if (int'(ptr_reg) + k < NREQ) begin
                    cand = int'(ptr_reg) + k;
                end else begin
                    cand = int'(ptr_reg) + k - NREQ;
                end
                cand_idx = PTR_W'(cand);
                if (elig[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    // One-hot decode of the winner for the next grant.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt_next[gi] = win_found && (win_idx == PTR_W'(gi));
        end
    endgenerate

    // Pointer moves to the port just after the winner, wrapping at NREQ.
    always_comb begin
        if (win_idx == PTR_W'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + PTR_W'(1);
        end
    end

    assign win_data = wdata_arr[win_idx];

    // Commit the winning write, update grant/strobe, pointer and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_reg    <= '0;
            wr_en_reg  <= 1'b0;
            q_reg      <= '0;
            wcount_reg <= '0;
            ptr_reg    <= '0;
        end else begin
            gnt_reg   <= gnt_next;
            wr_en_reg <= win_found;
            if (win_found) begin
                q_reg      <= win_data;
                ptr_reg    <= ptr_next;
                wcount_reg <= wcount_reg + CNT_W'(1);
            end
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.wr_en  = wr_en_reg;
    assign bus.q      = q_reg;
    assign bus.wcount = wcount_reg;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Self-checking bench for rr_reg_write_arbiter: a table of directed vectors,
// a randomized run against a behavioural model, and a counter-wrap sequence
// on a second instance with a 4-bit write counter.
module tb_rr_reg_write_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset6;

    rr_reg_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    rr_reg_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(4))     bus6 ();

    rr_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(4)) dut6 (
        .clk   (clk),
        .reset (reset6),
        .bus   (bus6)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vector: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        wr;
        logic [7:0]  q;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [31:0] wdata,
                                input logic [3:0] gnt, input logic wr, input logic [7:0] q,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.wdata = wdata;
        v.gnt = gnt; v.wr = wr; v.q = q; v.cnt = cnt;
        return v;
    endfunction

    // Behavioural model: last granted port (or -1), next search start,
    // register value and commit count.
    int          m_ptr;
    int          m_last;
    logic [7:0]  m_q;
    int          m_cnt;
    logic [3:0]  exp_gnt;
    logic        exp_wr;

    task automatic model_step(input logic rst, input logic [3:0] r, input logic [31:0] wd);
        int w;
        w = -1;
        if (rst) begin
            m_ptr = 0; m_last = -1; m_q = 8'h00; m_cnt = 0;
            exp_gnt = 4'b0000; exp_wr = 1'b0;
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (w < 0 && r[i] && i != m_last) w = i;
        end
        if (w >= 0) begin
            exp_gnt = 4'(1 << w);
            exp_wr  = 1'b1;
            m_q     = wd[w*8 +: 8];
            m_ptr   = (w + 1) % NREQ;
            m_cnt   = (m_cnt + 1) % 65536;
            m_last  = w;
        end else begin
            exp_gnt = 4'b0000;
            exp_wr  = 1'b0;
            m_last  = -1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.req    = '0;
        bus.wdata  = '0;
        reset6     = 1'b1;
        bus6.req   = '0;
        bus6.wdata = '0;

        // Reset held with all ports requesting
        vecs.push_back(mk(1, 4'hF, 32'hFFFFFFFF, 4'h0, 0, 8'h00, 16'd0));
        vecs.push_back(mk(1, 4'hF, 32'hFFFFFFFF, 4'h0, 0, 8'h00, 16'd0));
        // Single one-cycle pulse from port 2
        vecs.push_back(mk(0, 4'h4, 32'h00A50000, 4'h4, 1, 8'hA5, 16'd1));
        vecs.push_back(mk(0, 4'h0, 32'h00A50000, 4'h0, 0, 8'hA5, 16'd1));
        // All ports requesting: rotation 0,1,2,3,0
        vecs.push_back(mk(1, 4'hF, 32'h13121110, 4'h0, 0, 8'h00, 16'd0));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h1, 1, 8'h10, 16'd1));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h2, 1, 8'h11, 16'd2));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h4, 1, 8'h12, 16'd3));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h8, 1, 8'h13, 16'd4));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h1, 1, 8'h10, 16'd5));
        // Reset after the third grant, then restart from port 0
        vecs.push_back(mk(1, 4'hF, 32'h13121110, 4'h0, 0, 8'h00, 16'd0));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h1, 1, 8'h10, 16'd1));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h2, 1, 8'h11, 16'd2));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h4, 1, 8'h12, 16'd3));
        vecs.push_back(mk(1, 4'hF, 32'h13121110, 4'h0, 0, 8'h00, 16'd0));
        vecs.push_back(mk(0, 4'hF, 32'h13121110, 4'h1, 1, 8'h10, 16'd1));
        // Sole continuous requester is granted every other cycle
        vecs.push_back(mk(1, 4'h2, 32'h00003C00, 4'h0, 0, 8'h00, 16'd0));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h2, 1, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h0, 0, 8'h3C, 16'd1));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h2, 1, 8'h3C, 16'd2));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h0, 0, 8'h3C, 16'd2));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h2, 1, 8'h3C, 16'd3));
        vecs.push_back(mk(0, 4'h2, 32'h00003C00, 4'h0, 0, 8'h3C, 16'd3));

        foreach (vecs[n]) begin
            reset     = vecs[n].rst;
            bus.req   = vecs[n].req;
            bus.wdata = vecs[n].wdata;
            @(posedge clk);
            #1;
            $display("vec %0d rst=%0b req=%b gnt=%b wr_en=%0b q=%h wcount=%0d",
                     n, vecs[n].rst, vecs[n].req, bus.gnt, bus.wr_en, bus.q, bus.wcount);
            chk($sformatf("vec%0d_gnt", n),    32'(bus.gnt),    32'(vecs[n].gnt));
            chk($sformatf("vec%0d_wr_en", n),  32'(bus.wr_en),  32'(vecs[n].wr));
            chk($sformatf("vec%0d_q", n),      32'(bus.q),      32'(vecs[n].q));
            chk($sformatf("vec%0d_wcount", n), 32'(bus.wcount), 32'(vecs[n].cnt));
        end

        // Randomized traffic with occasional resets against the model
        model_step(1'b1, 4'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            logic        r_rst;
            logic [3:0]  r_req;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 31) == 0);
            r_req = 4'($urandom);
            r_wd  = $urandom;
            reset     = r_rst;
            bus.req   = r_req;
            bus.wdata = r_wd;
            model_step(r_rst, r_req, r_wd);
            @(posedge clk);
            #1;
            $display("rnd %0d rst=%0b req=%b gnt=%b q=%h wcount=%0d",
                     c, r_rst, r_req, bus.gnt, bus.q, bus.wcount);
            chk("rnd_gnt",    32'(bus.gnt),    32'(exp_gnt));
            chk("rnd_wr_en",  32'(bus.wr_en),  32'(exp_wr));
            chk("rnd_q",      32'(bus.q),      32'(m_q));
            chk("rnd_wcount", 32'(bus.wcount), 32'(m_cnt));
            chk("rnd_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("rnd_gnt_in_req", 32'(bus.gnt & ~r_req), 32'd0);
        end
        reset = 1'b1;

        // 4-bit counter wrap with two alternating requesters
        reset6     = 1'b1;
        bus6.req   = 4'b0011;
        bus6.wdata = 32'h0000BBAA;
        @(posedge clk);
        #1;
        chk("w6_reset_wcount", 32'(bus6.wcount), 32'd0);
        chk("w6_reset_gnt",    32'(bus6.gnt),    32'd0);
        reset6 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            $display("wrap %0d gnt=%b q=%h wcount=%0d", k, bus6.gnt, bus6.q, bus6.wcount);
            chk("w6_gnt",    32'(bus6.gnt),    (k % 2 == 1) ? 32'h1 : 32'h2);
            chk("w6_q",      32'(bus6.q),      (k % 2 == 1) ? 32'hAA : 32'hBB);
            chk("w6_wcount", 32'(bus6.wcount), 32'(k % 16));
        end
        reset6 = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
